ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. Sends command bytes to the keyboard on the shared PS/2 lines: Set LEDs 0xED, Reset 0xFF, Enable 0xF4, Resend 0xFE. The block sits beside the PS/2 receiver. It owns the open-drain pull-downs on ps2_clk/ps2_data. Its busy output tells top-level glue to blank the receiver while a command is in flight.

## Interface
- CLK_HZ, 50_000_000, system clock frequency (documentation only).
- INHIBIT_CYCLES, 6000, clock-low inhibit before request-to-send (120 us @ 50 MHz).
- START_TIMEOUT, 750_000, max cycles from clock release to first device falling edge (15 ms).
- XFER_TIMEOUT, 100_000, max cycles from first device falling edge to ACK (2 ms).
- FILTER_LEN, 8, consecutive equal samples required before the filtered ps2_clk changes.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- tx_valid  in  1  command byte valid.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; transfer occurs when tx_valid & tx_ready.
- ps2_clk_in  in  1  raw PS/2 clock pin level.
- ps2_data_in  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of every accepted command.
- ack_err  out  1  device did not ACK; valid from done until next accept.
- timeout_err  out  1  timeout occurred; valid from done until next accept.

## Operation
- Inputs: both pins pass through a 2-FF synchronizer. ps2_clk is additionally glitch-filtered. A fall pulse is generated on each filtered 1->0 transition.
- Accept: latch a 10-bit shift register {stop=1, parity, tx_data}, where parity = ~^tx_data (odd parity). Clear ack_err and timeout_err. Clear the bit counter (4 bits).
- FSM states: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
  - IDLE: both oe = 0. On accept -> INHIBIT.
  - INHIBIT: clk_oe = 1, data_oe = 0 for INHIBIT_CYCLES cycles, then -> REQ.
  - REQ: clk_oe = 1, data_oe = 1 (start bit) for 1 cycle. Then clk_oe = 0 with data_oe held at 1 -> SEND.
  - SEND: on each fall, data_oe = ~shift[0], shift right, count++.
    - The 10th fall drives the stop bit (data_oe = 0) -> ACK.
    - If no fall arrives within START_TIMEOUT before the first fall, set timeout_err -> WAIT_IDLE.
  - ACK: on the next fall, sample synced data. Set ack_err = data (1 = no ACK) -> WAIT_IDLE.
    - XFER_TIMEOUT, counted from the first fall, expires in SEND or ACK: set timeout_err -> WAIT_IDLE.
  - WAIT_IDLE: both oe = 0. Once synced clock and data are both 1, pulse done -> IDLE.
    - WAIT_IDLE also exits after START_TIMEOUT cycles with timeout_err set, so it cannot hang.
- Timers: one shared down/up counter of width $clog2(START_TIMEOUT+1), reloaded on each state entry. The XFER timer is a separate counter, started at the first fall.
- Error case: oe outputs are never both asserted after leaving REQ, except data_oe for bit values. Both oe are 0 in WAIT_IDLE and IDLE.

## Timing
- Reset: synchronous. All outputs read 0 except tx_ready = 1. Both lines are released on the next edge, including mid-transfer, and the FSM returns to IDLE.
- Input latency: 2 cycles to sync plus FILTER_LEN cycles before fall asserts. data_oe updates 1 cycle after fall.
- Accept-to-line: clk_oe rises the cycle after accept. data_oe rises INHIBIT_CYCLES cycles later.
- tx_valid while busy is ignored; no queueing.
- done and the error flags change in the same cycle. done never pulses without a prior accept.
- Glitches shorter than FILTER_LEN cycles on ps2_clk produce no fall.

## Structure
- Shared package ps2_pkg holds:
  - the state enum;
  - command constants PS2_CMD_SET_LED = 8'hED, PS2_CMD_RESET = 8'hFF, PS2_CMD_ENABLE = 8'hF4, PS2_CMD_RESEND = 8'hFE;
  - response constant PS2_RSP_ACK = 8'hFA.
- One sub-module, ps2_line_filter (synchronizer + FILTER_LEN stability counter + fall pulse). It is instantiated for ps2_clk. Data uses the synchronizer output only.
- Tristating stays in top: pin = oe ? 0 : z.

## Test plan
- Send 0xED, device model clocks at 12.5 kHz and ACKs. Required: bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; ack_err = 0; timeout_err = 0.
- Send 0xF4, device model does not pull data low on the 11th clock. Required: parity bit 0; done pulses with ack_err = 1.
- Send 0xFF, device never clocks. Required: timeout_err = 1 and done after START_TIMEOUT + WAIT_IDLE; both oe = 0.
- Send 0x00, device stops after 4 clocks. Required: timeout_err = 1 at XFER_TIMEOUT; lines released; the next command succeeds.
- Inject 3-cycle low glitches on ps2_clk during SEND of 0xED. Required: byte still received correctly, no extra bit shift.
- Assert reset_n = 0 during the 5th data bit. Required: next cycle both oe = 0, tx_ready = 1, done = 0; a subsequent 0xED completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWaitIdle
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

    // Host frame after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for a PS/2 line; pulses fall_o on a
// filtered 1->0 transition.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            meta_q, sync_q;
    logic            level_q, level_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // The filtered level only moves after FILTER_LEN consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        fall_d  = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                level_d = sync_q;
                fall_d  = ~sync_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= line_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Drives open-drain enables for ps2_clk and
// ps2_data; the pad logic turns each enable into pin = oe ? 0 : z.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned START_TIMEOUT  = 750_000,
    parameter int unsigned XFER_TIMEOUT   = 100_000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int unsigned TW = $clog2(START_TIMEOUT + 1);
    localparam int unsigned XW = $clog2(XFER_TIMEOUT + 1);

    if (CLK_HZ == 0 || INHIBIT_CYCLES == 0 || INHIBIT_CYCLES > START_TIMEOUT ||
        XFER_TIMEOUT == 0) begin : g_bad_params
        $error("ps2_host_tx: inconsistent timing parameters");
    end

    ps2_tx_state_e state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [XW-1:0] xfer_q, xfer_d;
    logic          started_q, started_d;
    logic          data_oe_q, data_oe_d;
    logic          pend_ack_q, pend_ack_d, pend_tmo_q, pend_tmo_d;
    logic          ack_err_q, ack_err_d, tmo_err_q, tmo_err_d;
    logic          done_q, done_d;
    logic          data_meta_q, data_sync_q;
    logic          clk_sync, clk_fall;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk_i (clk),
        .rst_ni(reset_n),
        .line_i(ps2_clk_in),
        .sync_o(clk_sync),
        .fall_o(clk_fall)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        xfer_d     = xfer_q;
        started_d  = started_q;
        data_oe_d  = data_oe_q;
        pend_ack_d = pend_ack_q;
        pend_tmo_d = pend_tmo_q;
        ack_err_d  = ack_err_q;
        tmo_err_d  = tmo_err_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d    = StInhibit;
                    shift_d    = ps2_frame(tx_data);
                    bit_cnt_d  = '0;
                    timer_d    = TW'(INHIBIT_CYCLES - 1);
                    started_d  = 1'b0;
                    pend_ack_d = 1'b0;
                    pend_tmo_d = 1'b0;
                    ack_err_d  = 1'b0;
                    tmo_err_d  = 1'b0;
                end
            end
            StInhibit: begin
                if (timer_q == '0) state_d = StReq;
                else timer_d = timer_q - TW'(1);
            end
            StReq: begin
                state_d   = StSend;
                timer_d   = TW'(START_TIMEOUT - 1);
                data_oe_d = 1'b1;
            end
            StSend: begin
                if (started_q && xfer_q != '0) xfer_d = xfer_q - XW'(1);
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (!started_q) begin
                        started_d = 1'b1;
                        xfer_d    = XW'(XFER_TIMEOUT - 1);
                    end
                    if (bit_cnt_q == 4'd9) state_d = StAck;
                end else if (started_q ? (xfer_q == '0) : (timer_q == '0)) begin
                    pend_tmo_d = 1'b1;
                    state_d    = StWaitIdle;
                    timer_d    = TW'(START_TIMEOUT - 1);
                end else if (!started_q) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            StAck: begin
                if (clk_fall) begin
                    pend_ack_d = data_sync_q;
                    state_d    = StWaitIdle;
                    timer_d    = TW'(START_TIMEOUT - 1);
                end else if (xfer_q == '0) begin
                    pend_tmo_d = 1'b1;
                    state_d    = StWaitIdle;
                    timer_d    = TW'(START_TIMEOUT - 1);
                end else begin
                    xfer_d = xfer_q - XW'(1);
                end
            end
            StWaitIdle: begin
                // Errors are published together with done so they are never seen early.
                if ((clk_sync && data_sync_q) || timer_q == '0) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    ack_err_d = pend_ack_q;
                    tmo_err_d = pend_tmo_q | ~(clk_sync & data_sync_q);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            timer_q     <= '0;
            xfer_q      <= '0;
            started_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            pend_ack_q  <= 1'b0;
            pend_tmo_q  <= 1'b0;
            ack_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            done_q      <= 1'b0;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            timer_q     <= timer_d;
            xfer_q      <= xfer_d;
            started_q   <= started_d;
            data_oe_q   <= data_oe_d;
            pend_ack_q  <= pend_ack_d;
            pend_tmo_q  <= pend_tmo_d;
            ack_err_q   <= ack_err_d;
            tmo_err_q   <= tmo_err_d;
            done_q      <= done_d;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign tx_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign ps2_clk_oe  = (state_q == StInhibit) || (state_q == StReq);
    assign ps2_data_oe = (state_q == StReq) || ((state_q == StSend) && data_oe_q);
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: wired-AND PS/2 lines, a keyboard model and a
// per-cycle checker driven by a command-level model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 20;
    localparam int unsigned ST  = 2000;
    localparam int unsigned XF  = 1500;
    localparam int unsigned FL  = 8;
    localparam int          H   = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ        (50_000_000),
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST),
        .XFER_TIMEOUT  (XF),
        .FILTER_LEN    (FL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, f1_cyc = 0, win_mode = 0;
    bit active = 1'b0;
    bit exp_ack = 1'b0, exp_tmo = 1'b0, held_ack = 1'b0, held_tmo = 1'b0;
    logic [9:0] rx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame as the keyboard must see it on rising edges: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_model(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    // Command-level model: k counts cycles since the accepting edge.
    always @(negedge clk) begin : cmp
        int k;
        cyc = cyc + 1;
        if (reset_n) begin
            k = cyc - acc_cyc;
            if (!active) begin
                chk("idle_busy", busy, 0);
                chk("idle_ready", tx_ready, 1);
                chk("idle_clk_oe", ps2_clk_oe, 0);
                chk("idle_data_oe", ps2_data_oe, 0);
                chk("idle_done", done, 0);
                chk("idle_ack_err", ack_err, held_ack);
                chk("idle_timeout_err", timeout_err, held_tmo);
            end else if (done) begin
                chk("done_busy", busy, 0);
                chk("done_ready", tx_ready, 1);
                chk("done_oe", {ps2_clk_oe, ps2_data_oe}, 0);
                chk("done_ack_err", ack_err, exp_ack);
                chk("done_timeout_err", timeout_err, exp_tmo);
                if (win_mode == 1)
                    chk("start_timeout_latency", (k >= INH + ST && k <= INH + ST + 12), 1);
                if (win_mode == 2)
                    chk("xfer_timeout_latency",
                        ((cyc - f1_cyc) >= XF && (cyc - f1_cyc) <= XF + FL + 20), 1);
                held_ack = exp_ack;
                held_tmo = exp_tmo;
                active   = 1'b0;
            end else begin
                chk("run_busy", busy, 1);
                chk("run_ready", tx_ready, 0);
                chk("run_errs_clear", {ack_err, timeout_err}, 0);
                if (k <= INH) chk("inhibit_oe", {ps2_clk_oe, ps2_data_oe}, 2'b10);
                else if (k == INH + 1) chk("req_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
                else if (k == INH + 2) chk("start_bit_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
                else chk("clk_released", ps2_clk_oe, 0);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        acc_cyc  = cyc;
        active   = 1'b1;
    endtask

    task automatic wait_done(input int max);
        int w = 0;
        while (active && w < max) begin
            tick(1);
            w++;
        end
        if (active) begin
            chk("done_seen", 0, 1);
            reset_n  = 1'b0;
            active   = 1'b0;
            held_ack = 1'b0;
            held_tmo = 1'b0;
            tick(1);
            reset_n = 1'b1;
        end
    endtask

    // Keyboard: waits for request-to-send, then produces nclk clock pulses.
    task automatic dev_xfer(input int nclk, input bit do_ack, input bit glitch,
                            output logic [9:0] bits);
        int w = 0;
        bits = '0;
        while (!(ps2_clk_in && !ps2_data_in) && w < 200) begin
            tick(1);
            w++;
        end
        if (w >= 200) begin
            chk("rts_seen", 0, 1);
            return;
        end
        tick(30);
        for (int i = 1; i <= nclk; i++) begin
            dev_clk_low = 1'b1;
            if (i == 1) f1_cyc = cyc;
            tick(H);
            dev_clk_low = 1'b0;
            if (i <= 10) bits[i-1] = ps2_data_in;
            if (i == 11) dev_data_low = 1'b0;
            if (glitch && i <= 9) begin
                tick(10);
                dev_clk_low = 1'b1;
                tick(3);
                dev_clk_low = 1'b0;
                tick(H - 13);
            end else if (do_ack && i == 10) begin
                tick(H / 2);
                dev_data_low = 1'b1;
                tick(H - H / 2);
            end else begin
                tick(H);
            end
        end
    endtask

    initial begin
        tick(3);
        chk("reset_ready", tx_ready, 1);
        chk("reset_outs", {busy, done, ack_err, timeout_err, ps2_clk_oe, ps2_data_oe}, 0);
        reset_n = 1'b1;
        tick(5);

        // Set LEDs with ACK; a tx_valid during the transfer must be ignored.
        exp_ack = 0; exp_tmo = 0; win_mode = 0;
        send(PS2_CMD_SET_LED);
        fork
            dev_xfer(11, 1'b1, 1'b0, rx);
            begin
                tick(INH + 200);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                tick(2);
                tx_valid = 1'b0;
            end
        join
        wait_done(600);
        chk("ed_bits", rx, 10'b11_1110_1101);

        // Enable without ACK.
        exp_ack = 1; exp_tmo = 0;
        send(PS2_CMD_ENABLE);
        dev_xfer(11, 1'b0, 1'b0, rx);
        wait_done(600);
        chk("f4_parity", rx[8], 0);
        chk("f4_frame", rx, frame_model(PS2_CMD_ENABLE));
        tick(10);

        // Reset command, device never clocks.
        exp_ack = 0; exp_tmo = 1; win_mode = 1;
        send(PS2_CMD_RESET);
        wait_done(INH + ST + 100);
        tick(10);

        // 0x00, device stops after 4 clocks; next command must succeed.
        exp_ack = 0; exp_tmo = 1; win_mode = 2;
        send(8'h00);
        dev_xfer(4, 1'b0, 1'b0, rx);
        wait_done(XF + 300);
        chk("zero_first_bits", rx[3:0], 4'b0000);
        exp_ack = 0; exp_tmo = 0; win_mode = 0;
        send(PS2_CMD_RESEND);
        dev_xfer(11, 1'b1, 1'b0, rx);
        wait_done(600);
        chk("fe_frame", rx, frame_model(PS2_CMD_RESEND));

        // Short clock glitches during SEND.
        send(PS2_CMD_SET_LED);
        dev_xfer(11, 1'b1, 1'b1, rx);
        wait_done(600);
        chk("ed_glitch_bits", rx, 10'b11_1110_1101);

        // Reset during the 5th data bit, then a clean transfer.
        send(PS2_CMD_SET_LED);
        dev_xfer(5, 1'b0, 1'b0, rx);
        chk("ed_first5_bits", rx[4:0], 5'b01101);
        reset_n  = 1'b0;
        active   = 1'b0;
        held_ack = 1'b0;
        held_tmo = 1'b0;
        tick(1);
        chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        reset_n = 1'b1;
        tick(5);
        send(PS2_CMD_SET_LED);
        dev_xfer(11, 1'b1, 1'b0, rx);
        wait_done(600);
        chk("ed_after_reset_bits", rx, 10'b11_1110_1101);

        tick(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before cycle 100000");
        $fatal(1);
    end

endmodule
